crossbar_arbiter: RTL
=====================

Name: crossbar_arbiter

Overview:
- Central scheduler for the 4x4 crossbar. Collects head-of-line requests from the four input queues: each queue has a valid flag plus a 2-bit destination select.
- Drives the per-output one-hot grant vectors that the queues index with their id.
- One round-robin arbiter per output port. Each grant is held long enough for the queue's alternating sample/idle phase to capture it, followed by a one-cycle gap so the queue head and select can settle.

Parameters:
- GRANT_HOLD, 2, cycles a grant is held asserted; legal range 1..15.
- CNT_W, 16, width of each per-output saturating grant counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-low: state clears on a clk edge where rst==0.
- enable  input  1  1 = new grants may be issued; 0 = no new issue, in-flight grants complete.
- req_valid  input  4  bit i = input queue i has a head entry.
- sel0  input  2  destination output port of input queue 0's head.
- sel1  input  2  destination output port of input queue 1's head.
- sel2  input  2  destination output port of input queue 2's head.
- sel3  input  2  destination output port of input queue 3's head.
- grant0  output  4  output port 0 grant; bit i = input i granted; one-hot or zero.
- grant1  output  4  output port 1 grant; same format.
- grant2  output  4  output port 2 grant; same format.
- grant3  output  4  output port 3 grant; same format.
- busy  output  4  bit p = output p's FSM is not IDLE.
- grant_count  output  4*CNT_W  saturating issue count; output p occupies bits [p*CNT_W +: CNT_W].

Behaviour:
- Request vector: for each output p, r_p[i] = req_valid[i] && (sel_i == p). Each input targets exactly one output, so an input can never hold two grants at once.
- All outputs are registered. A request visible at edge N produces a grant visible after edge N+1.
- Reset (rst==0 at an edge):
  - grant0..3 = 0, busy = 0, grant_count = 0.
  - All pointers = 0, all FSMs = IDLE.
  - Applies mid-grant: any held grant drops after that edge.
- Per-output FSM, IDLE state:
  - Issue condition: enable==1 and r_p != 0.
  - Winner w = first set bit of r_p scanning ptr_p, ptr_p+1, ... mod 4.
  - On issue: grant_p <= onehot(w); ptr_p <= (w+1) mod 4; hold_cnt <= GRANT_HOLD-1; count_p <= count_p+1, saturating at all-ones; go to GRANT.
  - Otherwise stay in IDLE with grant_p = 0.
- Per-output FSM, GRANT state:
  - grant_p stays constant while in this state.
  - Abort: if r_p[w]==0 (queue emptied or select changed), grant_p <= 0 and go to GAP.
  - Expiry: else if hold_cnt==0, grant_p <= 0 and go to GAP.
  - Otherwise hold_cnt decrements.
- Per-output FSM, GAP state: grant_p = 0 for exactly one cycle, then IDLE. Back-to-back grants to one output are therefore separated by at least one zero cycle.
- Timing: with GRANT_HOLD=2, one grant occupies 3 cycles (2 asserted + 1 gap).
- enable falling mid-GRANT: the grant runs to completion; only new issues are suppressed.
- The four outputs are fully independent and may all issue on the same edge.
- Round-robin fairness: a continuously requesting input waits at most 3 grant slots of its output.
- ptr_p wraps 3 -> 0. The pointer advances only on issue; aborts do not move it back.
- sel values are always in 0..3 (2 bits), so no illegal destination exists.

Decomposition:
- Package crossbar_pkg:
  - N_PORTS = 4, PORT_W = 2.
  - FSM state type: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - Round-robin pick function: 4-bit request plus 2-bit pointer in, 2-bit index and found flag out.
- Sub-module rr_port_arbiter: one output port's FSM, pointer, hold counter and grant counter. Instantiated 4 times, with port index p as a parameter.
- The top level only forms r_p and flattens grant_count.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=4'hF → all grants 4'h0, busy 4'h0, counts 0. Release rst → grant0 = 4'b0001 one cycle later (all sel=0, ptr 0).
- Round-robin: all four inputs request output 0 continuously, GRANT_HOLD=2 → grant0 sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000, then 0001 again; grant_count[p=0] = 4 after the fourth issue.
- Parallel outputs: sel0..3 = 0,1,2,3, all valid → grant0=0001, grant1=0010, grant2=0100, grant3=1000 on the same cycle; busy = 4'hF.
- Abort: input 2 is granted on output 1; req_valid[2] drops in the first GRANT cycle → grant1 = 0 the next cycle, one GAP cycle, then the next requester is served.
- Enable and reset mid-grant:
  - enable=0 during GRANT → the grant completes and no new grant follows while enable=0.
  - rst=0 during GRANT → the grant clears after that edge and ptr restarts at 0.
- Saturation: CNT_W=2 with continuous requests on output 3 → count goes 1,2,3 and stays 3.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the 4x4 crossbar scheduler.
// Holds the per-output FSM state encoding and the round-robin pick function.
package crossbar_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic              found;
        logic [PORT_W-1:0] idx;
    } pick_t;

    // Scan req starting at ptr and wrapping; the first set bit wins.
    function automatic pick_t rr_pick(input logic [N_PORTS-1:0] req,
                                      input logic [PORT_W-1:0]  ptr);
        pick_t             res;
        logic [PORT_W-1:0] cand;
        res = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = ptr + PORT_W'(k);
            if (!res.found && req[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_port_arbiter.sv
// Round-robin arbiter for a single crossbar output: FSM, rotating pointer,
// grant hold timer and saturating issue counter.
module rr_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int PORT       = 0,
    parameter int GRANT_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_PORTS-1:0]   req,
    output logic [N_PORTS-1:0]   grant,
    output logic                 busy,
    output logic [CNT_W-1:0]     grant_count
);

    arb_state_t        state;
    logic [PORT_W-1:0] ptr;
    logic [PORT_W-1:0] winner;
    logic [3:0]        hold_cnt;
    pick_t             pick;

    always_comb pick = rr_pick(req, ptr);

    assign busy = (state != IDLE);

    // GAP already shows grant==0 for its one cycle, so the edge leaving GAP
    // may issue directly; this keeps a full slot at GRANT_HOLD+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            winner      <= '0;
            hold_cnt    <= '0;
            grant_count <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (enable && pick.found) begin
                        grant    <= N_PORTS'(1) << pick.idx;
                        winner   <= pick.idx;
                        ptr      <= pick.idx + 1'b1;
                        hold_cnt <= 4'(GRANT_HOLD - 1);
                        if (grant_count != '1)
                            grant_count <= grant_count + 1'b1;
                        state    <= GRANT;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[winner] || hold_cnt == 4'd0) begin
                        grant <= '0;
                        state <= GAP;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
                     $onehot0(grant) && (PORT < N_PORTS));

endmodule

// File: rtl/crossbar_arbiter.sv
// Central 4x4 crossbar scheduler: forms per-output request vectors from the
// queue heads and runs one round-robin arbiter per output.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int GRANT_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [N_PORTS-1:0]         req_valid,
    input  logic [PORT_W-1:0]          sel0,
    input  logic [PORT_W-1:0]          sel1,
    input  logic [PORT_W-1:0]          sel2,
    input  logic [PORT_W-1:0]          sel3,
    output logic [N_PORTS-1:0]         grant0,
    output logic [N_PORTS-1:0]         grant1,
    output logic [N_PORTS-1:0]         grant2,
    output logic [N_PORTS-1:0]         grant3,
    output logic [N_PORTS-1:0]         busy,
    output logic [N_PORTS*CNT_W-1:0]   grant_count
);

    logic [PORT_W-1:0]  dest      [N_PORTS];
    logic [N_PORTS-1:0] req_port  [N_PORTS];
    logic [N_PORTS-1:0] grant_arr [N_PORTS];

    assign dest[0] = sel0;
    assign dest[1] = sel1;
    assign dest[2] = sel2;
    assign dest[3] = sel3;

    // Each input targets exactly one output, so no input can be granted twice.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            req_port[p] = '0;
            for (int i = 0; i < N_PORTS; i++)
                req_port[p][i] = req_valid[i] && (dest[i] == PORT_W'(p));
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        rr_port_arbiter #(
            .PORT       (p),
            .GRANT_HOLD (GRANT_HOLD),
            .CNT_W      (CNT_W)
        ) u_arb (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable),
            .req         (req_port[p]),
            .grant       (grant_arr[p]),
            .busy        (busy[p]),
            .grant_count (grant_count[p*CNT_W +: CNT_W])
        );
    end

    assign grant0 = grant_arr[0];
    assign grant1 = grant_arr[1];
    assign grant2 = grant_arr[2];
    assign grant3 = grant_arr[3];

endmodule
